// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared state encoding and fetch constants for fetch_ctrl
package fetch_ctrl_pkg;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_KILL = 2'd2
   } state_t;

   localparam int unsigned FETCH_BYTES      = 8;
   localparam logic [63:0] FETCH_ALIGN_MASK = 64'(FETCH_BYTES - 1);
   localparam logic [63:0] DEFAULT_RESET_PC = 64'h8000_0000;

endpackage

// File: rtl/fetch_next_pc.sv
// rtl/fetch_next_pc.sv - next fetch PC priority mux: redirect > predicted-taken > sequential
module fetch_next_pc
   import fetch_ctrl_pkg::*;
#(
   parameter int ADDR_W = 64
) (
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_target,
   input  logic              predict_valid,
   input  logic              predict_taken,
   input  logic [ADDR_W-1:0] predict_target,
   input  logic [ADDR_W-1:0] base_pc,
   output logic [ADDR_W-1:0] next_pc
);

   logic [ADDR_W-1:0] seq_pc;

   // Sequential successor is the next aligned fetch block; addition wraps naturally.
   always_comb begin
      seq_pc = (base_pc & ~ADDR_W'(FETCH_ALIGN_MASK)) + ADDR_W'(FETCH_BYTES);
      if (redirect_valid) begin
         next_pc = redirect_target;
      end else if (predict_valid && predict_taken) begin
         next_pc = predict_target;
      end else begin
         next_pc = seq_pc;
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch PC sequencer and I-cache request tracker (optional FETCH_CTRL_PERF_EN counters)
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int                ADDR_W   = 64,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              io_i_redirect_valid,
   input  logic [ADDR_W-1:0] io_i_redirect_target,
   input  logic              io_i_predict_valid,
   input  logic              io_i_predict_taken,
   input  logic [ADDR_W-1:0] io_i_predict_target,
   input  logic              io_i_queue_ready,
   output logic              io_o_icache_req_valid,
   input  logic              io_i_icache_req_ready,
   output logic [ADDR_W-1:0] io_o_icache_req_addr,
   input  logic              io_i_icache_resp_valid,
   output logic [ADDR_W-1:0] io_o_pc,
   output logic              io_o_resp_valid,
   output logic              io_o_flush,
   output logic              io_o_stall,
   output logic              io_o_busy
`ifdef FETCH_CTRL_PERF_EN
   ,
   output logic [31:0]       io_o_perf_req_cnt,
   output logic [31:0]       io_o_perf_kill_cnt,
   output logic [31:0]       io_o_perf_stall_cnt
`endif
);

   state_t            state_q;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] inflight_pc_q;
   logic [ADDR_W-1:0] next_pc;
   logic              in_req;
   logic              req_fire;
   logic              resp_fire;

   // Next PC after a response; also resolves redirect priority for the kill paths.
   fetch_next_pc #(
      .ADDR_W (ADDR_W)
   ) u_next_pc (
      .redirect_valid  (io_i_redirect_valid),
      .redirect_target (io_i_redirect_target),
      .predict_valid   (io_i_predict_valid),
      .predict_taken   (io_i_predict_taken),
      .predict_target  (io_i_predict_target),
      .base_pc         (inflight_pc_q),
      .next_pc         (next_pc)
   );

   assign in_req    = (state_q == S_REQ);
   assign req_fire  = io_o_icache_req_valid & io_i_icache_req_ready;
   assign resp_fire = ~reset & ~in_req & io_i_icache_resp_valid;

   // Issue only when the downstream queue can absorb the response and no redirect is pending.
   assign io_o_icache_req_valid = ~reset & in_req & io_i_queue_ready & ~io_i_redirect_valid;
   assign io_o_icache_req_addr  = reset ? '0 : (pc_q & ~ADDR_W'(FETCH_ALIGN_MASK));
   assign io_o_resp_valid       = resp_fire;
   assign io_o_flush            = resp_fire & ((state_q == S_KILL) | io_i_redirect_valid);
   assign io_o_pc               = resp_fire ? inflight_pc_q : '0;
   assign io_o_stall            = ~resp_fire;
   assign io_o_busy             = ~reset & ~in_req;

   // Fetch state machine: issue, wait for the response, or wait out a stale response.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= S_REQ;
         pc_q          <= RESET_PC;
         inflight_pc_q <= '0;
      end else begin
         case (state_q)
            S_REQ: begin
               if (io_i_redirect_valid) begin
                  pc_q <= io_i_redirect_target;
               end else if (req_fire) begin
                  inflight_pc_q <= pc_q;
                  state_q       <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (io_i_icache_resp_valid) begin
                  pc_q    <= next_pc;
                  state_q <= S_REQ;
               end else if (io_i_redirect_valid) begin
                  pc_q    <= io_i_redirect_target;
                  state_q <= S_KILL;
               end
            end
            S_KILL: begin
               if (io_i_redirect_valid) begin
                  pc_q <= io_i_redirect_target;
               end
               if (io_i_icache_resp_valid) begin
                  state_q <= S_REQ;
               end
            end
            default: state_q <= S_REQ;
         endcase
      end
   end

`ifdef FETCH_CTRL_PERF_EN
   // Saturating event counters for request, kill and queue-stall activity.
   always_ff @(posedge clock) begin
      if (reset) begin
         io_o_perf_req_cnt   <= '0;
         io_o_perf_kill_cnt  <= '0;
         io_o_perf_stall_cnt <= '0;
      end else begin
         if (req_fire && (io_o_perf_req_cnt != '1)) begin
            io_o_perf_req_cnt <= io_o_perf_req_cnt + 32'd1;
         end
         if (io_o_flush && (io_o_perf_kill_cnt != '1)) begin
            io_o_perf_kill_cnt <= io_o_perf_kill_cnt + 32'd1;
         end
         if (in_req && !io_i_queue_ready && (io_o_perf_stall_cnt != '1)) begin
            io_o_perf_stall_cnt <= io_o_perf_stall_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl
module tb_fetch_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic        redirect_valid;
   logic [63:0] redirect_target;
   logic        predict_valid;
   logic        predict_taken;
   logic [63:0] predict_target;
   logic        queue_ready;
   logic        req_ready;
   logic        resp_valid;

   logic        req_valid_a, resp_valid_a, flush_a, stall_a, busy_a;
   logic [63:0] req_addr_a, pc_a;
   logic        req_valid_b, resp_valid_b, flush_b, stall_b, busy_b;
   logic [63:0] req_addr_b, pc_b;
`ifdef FETCH_CTRL_PERF_EN
   logic [31:0] req_cnt_a, kill_cnt_a, stall_cnt_a;
   logic [31:0] req_cnt_b, kill_cnt_b, stall_cnt_b;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic [63:0] pc;
      logic        flush;
      logic        stall;
   } resp_t;

   logic [63:0] reqs_a[$];
   logic [63:0] reqs_b[$];
   resp_t       resps_a[$];
   resp_t       resps_b[$];

   // Transaction-level model: fetch PC, one outstanding request, stale marker.
   logic [63:0] m_pc       = 64'h8000_0000;
   logic        m_out      = 1'b0;
   logic        m_stale    = 1'b0;
   logic [63:0] m_inflight = 64'h0;

   always #5 clock = ~clock;

   fetch_ctrl u_dut_a (
      .clock                  (clock),
      .reset                  (reset),
      .io_i_redirect_valid    (redirect_valid),
      .io_i_redirect_target   (redirect_target),
      .io_i_predict_valid     (predict_valid),
      .io_i_predict_taken     (predict_taken),
      .io_i_predict_target    (predict_target),
      .io_i_queue_ready       (queue_ready),
      .io_o_icache_req_valid  (req_valid_a),
      .io_i_icache_req_ready  (req_ready),
      .io_o_icache_req_addr   (req_addr_a),
      .io_i_icache_resp_valid (resp_valid),
      .io_o_pc                (pc_a),
      .io_o_resp_valid        (resp_valid_a),
      .io_o_flush             (flush_a),
      .io_o_stall             (stall_a),
      .io_o_busy              (busy_a)
`ifdef FETCH_CTRL_PERF_EN
      ,
      .io_o_perf_req_cnt      (req_cnt_a),
      .io_o_perf_kill_cnt     (kill_cnt_a),
      .io_o_perf_stall_cnt    (stall_cnt_a)
`endif
   );

   fetch_ctrl #(
      .RESET_PC (64'h8000_0004)
   ) u_dut_b (
      .clock                  (clock),
      .reset                  (reset),
      .io_i_redirect_valid    (redirect_valid),
      .io_i_redirect_target   (redirect_target),
      .io_i_predict_valid     (predict_valid),
      .io_i_predict_taken     (predict_taken),
      .io_i_predict_target    (predict_target),
      .io_i_queue_ready       (queue_ready),
      .io_o_icache_req_valid  (req_valid_b),
      .io_i_icache_req_ready  (req_ready),
      .io_o_icache_req_addr   (req_addr_b),
      .io_i_icache_resp_valid (resp_valid),
      .io_o_pc                (pc_b),
      .io_o_resp_valid        (resp_valid_b),
      .io_o_flush             (flush_b),
      .io_o_stall             (stall_b),
      .io_o_busy              (busy_b)
`ifdef FETCH_CTRL_PERF_EN
      ,
      .io_o_perf_req_cnt      (req_cnt_b),
      .io_o_perf_kill_cnt     (kill_cnt_b),
      .io_o_perf_stall_cnt    (stall_cnt_b)
`endif
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Every cycle: compare instance A against the model, log traffic, then advance the model.
   always @(negedge clock) begin
      logic        e_req, e_resp, e_flush;
      e_req   = !reset && !m_out && queue_ready && !redirect_valid;
      e_resp  = !reset && m_out && resp_valid;
      e_flush = e_resp && (m_stale || redirect_valid);
      chk("req_valid", req_valid_a, e_req);
      chk("req_addr", req_addr_a, reset ? 64'h0 : (m_pc & ~64'h7));
      chk("resp_valid", resp_valid_a, e_resp);
      chk("flush", flush_a, e_flush);
      chk("stall", stall_a, !e_resp);
      chk("pc", pc_a, e_resp ? m_inflight : 64'h0);
      chk("busy", busy_a, !reset && m_out);

      if (req_valid_a && req_ready) reqs_a.push_back(req_addr_a);
      if (req_valid_b && req_ready) reqs_b.push_back(req_addr_b);
      if (resp_valid_a) resps_a.push_back('{pc_a, flush_a, stall_a});
      if (resp_valid_b) resps_b.push_back('{pc_b, flush_b, stall_b});

      if (reset) begin
         m_pc    = 64'h8000_0000;
         m_out   = 1'b0;
         m_stale = 1'b0;
      end else if (!m_out) begin
         if (redirect_valid) begin
            m_pc = redirect_target;
         end else if (e_req && req_ready) begin
            m_out      = 1'b1;
            m_stale    = 1'b0;
            m_inflight = m_pc;
         end
      end else if (resp_valid) begin
         m_out = 1'b0;
         if (redirect_valid)                        m_pc = redirect_target;
         else if (m_stale)                          m_pc = m_pc;
         else if (predict_valid && predict_taken)   m_pc = predict_target;
         else                                       m_pc = (m_inflight & ~64'h7) + 64'd8;
         m_stale = 1'b0;
      end else if (redirect_valid) begin
         m_stale = 1'b1;
         m_pc    = redirect_target;
      end
   end

   task automatic step(input logic rv, input logic [63:0] rt, input logic pt,
                       input logic [63:0] ptg, input logic qr, input logic rr, input logic rsp);
      redirect_valid  = rv;
      redirect_target = rt;
      predict_valid   = pt;
      predict_taken   = pt;
      predict_target  = ptg;
      queue_ready     = qr;
      req_ready       = rr;
      resp_valid      = rsp;
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      redirect_valid = 1'b0; redirect_target = '0;
      predict_valid = 1'b0; predict_taken = 1'b0; predict_target = '0;
      queue_ready = 1'b1; req_ready = 1'b1; resp_valid = 1'b0;
      #2;
      chk("rst_stall", stall_a, 1'b1);
      chk("rst_req_valid", req_valid_a, 1'b0);
      chk("rst_busy", busy_a, 1'b0);
      @(posedge clock); #1;
      @(posedge clock); #1;
      reset = 1'b0;

      // Sequential fetch, response one cycle after each request
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 0, 1, 1, 0);
         step(0, 0, 0, 0, 1, 1, 1);
      end
      // Predicted taken
      step(0, 0, 0, 0, 1, 1, 0);
      step(0, 0, 1, 64'h8000_1000, 1, 1, 1);
      // Redirect two cycles before the response
      step(0, 0, 0, 0, 1, 1, 0);
      step(1, 64'h9000_0000, 0, 0, 1, 1, 0);
      step(0, 0, 0, 0, 1, 1, 0);
      step(0, 0, 0, 0, 1, 1, 1);
`ifdef FETCH_CTRL_PERF_EN
      chk("kill_cnt_mid", kill_cnt_a, 1);
`endif
      // Redirect coincident with response, predict also asserted
      step(0, 0, 0, 0, 1, 1, 0);
      step(1, 64'hA000_0000, 1, 64'h8000_1000, 1, 1, 1);
      step(0, 0, 0, 0, 1, 1, 0);
      step(0, 0, 0, 0, 1, 1, 1);
      // Two redirects while killing: last one wins
      step(0, 0, 0, 0, 1, 1, 0);
      step(1, 64'hB000_0000, 0, 0, 1, 1, 0);
      step(1, 64'hB000_0100, 0, 0, 1, 1, 0);
      step(0, 0, 0, 0, 1, 1, 1);
      // I-cache backpressure for one cycle
      step(0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 1, 1, 0);
      step(0, 0, 0, 0, 1, 1, 1);
      // Redirect to top of address space, queue not ready for 5 cycles, then wrap
      step(1, 64'hFFFF_FFFF_FFFF_FFF8, 0, 0, 1, 1, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1, 0);
      chk("no_req_when_queue_full", reqs_a.size(), 9);
      step(0, 0, 0, 0, 1, 1, 0);
      step(0, 0, 0, 0, 1, 1, 1);
      step(0, 0, 0, 0, 1, 1, 0);
      step(0, 0, 0, 0, 1, 1, 1);
      step(0, 0, 0, 0, 1, 0, 0);

      chk("req_count", reqs_a.size(), 11);
      chk("req0", reqs_a[0], 64'h8000_0000);
      chk("req1", reqs_a[1], 64'h8000_0008);
      chk("req2", reqs_a[2], 64'h8000_0010);
      chk("req_pred", reqs_a[4], 64'h8000_1000);
      chk("req_redir", reqs_a[5], 64'h9000_0000);
      chk("req_redir_beats_pred", reqs_a[6], 64'hA000_0000);
      chk("req_last_redir", reqs_a[8], 64'hB000_0100);
      chk("req_top", reqs_a[9], 64'hFFFF_FFFF_FFFF_FFF8);
      chk("req_wrap", reqs_a[10], 64'h0);
      chk("resp_count", resps_a.size(), 11);
      chk("resp0_pc", resps_a[0].pc, 64'h8000_0000);
      chk("resp2_pc", resps_a[2].pc, 64'h8000_0010);
      chk("resp0_flush", resps_a[0].flush, 1'b0);
      chk("kill_resp_flush", resps_a[4].flush, 1'b1);
      chk("kill_resp_stall", resps_a[4].stall, 1'b0);
      chk("coinc_resp_flush", resps_a[5].flush, 1'b1);
      chk("double_kill_flush", resps_a[7].flush, 1'b1);
      chk("b_req0", reqs_b[0], 64'h8000_0000);
      chk("b_req1", reqs_b[1], 64'h8000_0008);
      chk("b_resp0_pc", resps_b[0].pc, 64'h8000_0004);
`ifdef FETCH_CTRL_PERF_EN
      chk("req_cnt", req_cnt_a, 11);
      chk("kill_cnt", kill_cnt_a, 3);
      chk("stall_cnt", stall_cnt_a, 5);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences the instruction-fetch stage: owns the fetch PC and issues 8-byte-aligned I-cache requests.
- Tracks the single outstanding request and delivers each returned response to the fetch-result stage together with its PC and a stall/flush qualifier.
- Applies backend redirects and taken branch predictions, and discards responses made stale by a redirect.
- Sits between the branch predictor/backend redirect logic and the I-cache, upstream of the fetch-result unpacker.

Parameters:
- RESET_PC, 64'h8000_0000, PC loaded on reset; bit 2 may be set; bits 1:0 must be zero.
- ADDR_W, 64, PC/address width.

Ports:
- clock  in  1  core clock
- reset  in  1  synchronous, active-high reset
- io_i_redirect_valid  in  1  backend redirect (mispredict/exception); highest priority
- io_i_redirect_target  in  ADDR_W  redirect PC
- io_i_predict_valid  in  1  predictor result for the PC currently in flight; sampled with the response
- io_i_predict_taken  in  1  predicted taken
- io_i_predict_target  in  ADDR_W  predicted target
- io_i_queue_ready  in  1  downstream fetch queue can accept one pack
- io_o_icache_req_valid  out  1  request valid
- io_i_icache_req_ready  in  1  I-cache accepts request
- io_o_icache_req_addr  out  ADDR_W  {pc[63:3],3'b0}
- io_i_icache_resp_valid  in  1  response for the outstanding request
- io_o_pc  out  ADDR_W  unaligned PC of the delivered response (drives the fetch-result io_i_pc)
- io_o_resp_valid  out  1  response delivered this cycle
- io_o_flush  out  1  drop the current response (drives the fetch-result io_i_flush)
- io_o_stall  out  1  no valid fetch this cycle (drives the fetch-result io_i_stall)
- io_o_busy  out  1  request outstanding

Behaviour:
- Registers:
  - pc_q: current fetch PC.
  - inflight_pc_q: PC of the issued request.
  - state_q, one of S_REQ, S_WAIT, S_KILL.
- Reset values:
  - pc_q=RESET_PC, state_q=S_REQ.
  - req_valid=0 during the reset cycle; all other outputs 0, except io_o_stall=1.
- S_REQ:
  - io_o_icache_req_valid = io_i_queue_ready & ~io_i_redirect_valid.
  - On handshake: inflight_pc_q<=pc_q; go to S_WAIT.
  - Redirect in S_REQ: pc_q<=redirect_target; stay in S_REQ; request issues no earlier than the next cycle.
- S_WAIT, resp_valid without redirect:
  - io_o_resp_valid=1, io_o_pc=inflight_pc_q, io_o_stall=0, io_o_flush=0.
  - If predict_valid & predict_taken: pc_q<=predict_target.
  - Otherwise pc_q<={inflight_pc_q[63:3],3'b0}+8, wrapping modulo 2^ADDR_W.
  - Go to S_REQ. Minimum request-to-request spacing is 2 cycles.
- S_WAIT, redirect without resp:
  - pc_q<=redirect_target; go to S_KILL.
- S_WAIT, redirect and resp in the same cycle:
  - Response delivered with io_o_flush=1, so the fetch result produces no valid slots.
  - pc_q<=redirect_target; go to S_REQ.
- S_KILL:
  - No requests issued.
  - On resp_valid: io_o_resp_valid=1, io_o_flush=1; go to S_REQ.
  - A further redirect in S_KILL overwrites pc_q only; the last redirect wins.
- io_o_stall=1 in every cycle where io_o_resp_valid=0.
- Response data is never buffered. The downstream fetch queue must hold ready stable from request to response, guaranteed by io_i_queue_ready gating the issue.
- Redirect priority: redirect > predicted-taken > sequential.
- io_o_busy = (state_q != S_REQ).
- Reset asserted mid-request: the state machine returns to S_REQ and pc_q to RESET_PC. The I-cache is reset on the same reset, so no stale response arrives.

Optional Feature:
- FETCH_CTRL_PERF_EN
- Defined:
  - Adds 32-bit saturating counters with outputs io_o_perf_req_cnt, io_o_perf_kill_cnt and io_o_perf_stall_cnt.
  - req_cnt counts request handshakes; kill_cnt counts responses with flush=1; stall_cnt counts S_REQ cycles with queue_ready=0.
  - All counters reset to 0.
- Undefined: the ports and logic are absent and all other behaviour is identical.

Decomposition:
- Shared package holds:
  - the state encoding (S_REQ=2'd0, S_WAIT=2'd1, S_KILL=2'd2);
  - FETCH_BYTES=8 and FETCH_ALIGN_MASK;
  - the RESET_PC default.
- One sub-module, fetch_next_pc: combinational next-PC priority mux (redirect / predict / sequential align+8).

Test Plan:
- Reset, then queue_ready=1 and req_ready=1, response one cycle after each request:
  - addresses 0x8000_0000, 0x8000_0008, 0x8000_0010 on alternating cycles;
  - io_o_pc matches each address; flush=0.
- RESET_PC=0x8000_0004:
  - first request addr 0x8000_0000, io_o_pc=0x8000_0004;
  - next request 0x8000_0008.
- Response with predict_valid=1, taken=1, target=0x8000_1000 -> next request addr 0x8000_1000.
- Redirect to 0x9000_0000 two cycles before the response arrives:
  - response delivered with flush=1, stall=0;
  - next request 0x9000_0000;
  - kill counter (if enabled) = 1.
- Redirect to 0xA000_0000 coincident with the response (predict taken to 0x8000_1000 also asserted):
  - flush=1;
  - next request 0xA000_0000 (redirect beats predict).
- pc=0xFFFF_FFFF_FFFF_FFF8, sequential response -> next request 0x0 (wrap). Also hold queue_ready=0 for 5 cycles -> no request issued; stall=1 throughout.
